// File: rtl/dzcpu_useq.sv
// Micro-sequencer for the dzcpu core: latches opcodes, dispatches them through the
// opcode/CB lookup tables and walks the microcode ROM one micro-op per cycle.
module dzcpu_useq #(
  parameter int FLOW_W = 3,
  parameter int OP_W   = 5,
  parameter int REG_W  = 4,
  parameter logic [FLOW_W-1:0] FLOW_OP        = 3'd0,
  parameter logic [FLOW_W-1:0] FLOW_INC       = 3'd1,
  parameter logic [FLOW_W-1:0] FLOW_EOF       = 3'd2,
  parameter logic [FLOW_W-1:0] FLOW_INC_EOF   = 3'd3,
  parameter logic [FLOW_W-1:0] FLOW_INC_EOF_Z = 3'd4,
  parameter logic [OP_W-1:0]   OP_JCB         = 5'd31
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMemData,
  input  logic              iStall,
  input  logic              iZeroFlag,
  input  logic [7:0]        iUopFlowIdx,
  input  logic [7:0]        iCbUopFlowIdx,
  input  logic [11:0]       iUop,
  output logic [7:0]        oMop,
  output logic [7:0]        oCbMop,
  output logic [7:0]        oUopAddr,
  output logic              oUopValid,
  output logic [OP_W-1:0]   oUopOp,
  output logic [REG_W-1:0]  oUopReg,
  output logic              oPcInc,
  output logic              oMopDone
);

  typedef enum logic [1:0] {S_FETCH, S_DISPATCH, S_CBDISPATCH, S_EXEC} state_t;

  state_t state, state_nxt;
  logic [7:0] mop, mop_nxt;
  logic [7:0] cb_mop, cb_mop_nxt;
  logic [7:0] uaddr, uaddr_nxt;
  logic uop_valid, pc_inc, mop_done;

  logic [FLOW_W-1:0] flow;
  logic [OP_W-1:0]   uop_op;
  logic [REG_W-1:0]  uop_reg;

  assign flow    = iUop[OP_W+REG_W +: FLOW_W];
  assign uop_op  = iUop[REG_W +: OP_W];
  assign uop_reg = iUop[0 +: REG_W];

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state  <= S_FETCH;
      mop    <= '0;
      cb_mop <= '0;
      uaddr  <= '0;
    end else begin
      state  <= state_nxt;
      mop    <= mop_nxt;
      cb_mop <= cb_mop_nxt;
      uaddr  <= uaddr_nxt;
    end
  end

  // A stall leaves every register at its current value and silences all strobes.
  always_comb begin
    state_nxt  = state;
    mop_nxt    = mop;
    cb_mop_nxt = cb_mop;
    uaddr_nxt  = uaddr;
    uop_valid  = 1'b0;
    pc_inc     = 1'b0;
    mop_done   = 1'b0;
    if (!iStall) begin
      unique case (state)
        S_FETCH: begin
          mop_nxt   = iMemData;
          state_nxt = S_DISPATCH;
        end
        S_DISPATCH: begin
          uaddr_nxt = iUopFlowIdx;
          state_nxt = S_EXEC;
        end
        S_CBDISPATCH: begin
          uaddr_nxt = iCbUopFlowIdx;
          state_nxt = S_EXEC;
        end
        S_EXEC: begin
          pc_inc = (flow == FLOW_INC) || (flow == FLOW_INC_EOF) || (flow == FLOW_INC_EOF_Z);
          // The CB jump replaces the flow advance; only the PC request survives.
          if (uop_op == OP_JCB) begin
            cb_mop_nxt = iMemData;
            state_nxt  = S_CBDISPATCH;
          end else begin
            uop_valid = 1'b1;
            case (flow)
              FLOW_EOF, FLOW_INC_EOF: begin
                mop_done  = 1'b1;
                state_nxt = S_FETCH;
              end
              FLOW_INC_EOF_Z: begin
                if (iZeroFlag) begin
                  uop_valid = 1'b0;
                  mop_done  = 1'b1;
                  state_nxt = S_FETCH;
                end else begin
                  uaddr_nxt = uaddr + 8'd1;
                end
              end
              FLOW_OP, FLOW_INC: uaddr_nxt = uaddr + 8'd1;
              default:           uaddr_nxt = uaddr + 8'd1;
            endcase
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // Every output reads as zero for as long as reset is held.
  assign oMop      = iReset ? '0 : mop;
  assign oCbMop    = iReset ? '0 : cb_mop;
  assign oUopAddr  = iReset ? '0 : uaddr;
  assign oUopOp    = iReset ? '0 : uop_op;
  assign oUopReg   = iReset ? '0 : uop_reg;
  assign oUopValid = uop_valid & ~iReset;
  assign oPcInc    = pc_inc & ~iReset;
  assign oMopDone  = mop_done & ~iReset;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: closed-loop memory/LUT/ROM around the sequencer, a trace-level
// reference model checked every cycle, plus hand-computed cycle expectations.
module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMemData;
  logic        iStall = 1'b0;
  logic        iZeroFlag;
  logic [7:0]  iUopFlowIdx;
  logic [7:0]  iCbUopFlowIdx;
  logic [11:0] iUop;
  logic [7:0]  oMop, oCbMop, oUopAddr;
  logic        oUopValid, oPcInc, oMopDone;
  logic [4:0]  oUopOp;
  logic [3:0]  oUopReg;

  logic [7:0]  prog [256];
  logic [7:0]  lut [256];
  logic [7:0]  cblut [256];
  logic [11:0] rom [256];
  logic [7:0]  mem_pc = 8'd0;
  logic        zero = 1'b0;
  logic        armed = 1'b0;
  int          total_count = 0;
  int          pass_count = 0;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iStall(iStall),
    .iZeroFlag(iZeroFlag), .iUopFlowIdx(iUopFlowIdx), .iCbUopFlowIdx(iCbUopFlowIdx),
    .iUop(iUop), .oMop(oMop), .oCbMop(oCbMop), .oUopAddr(oUopAddr),
    .oUopValid(oUopValid), .oUopOp(oUopOp), .oUopReg(oUopReg),
    .oPcInc(oPcInc), .oMopDone(oMopDone)
  );

  always #5 iClock = ~iClock;

  assign iMemData      = prog[mem_pc];
  assign iZeroFlag     = zero;
  assign iUopFlowIdx   = lut[oMop];
  assign iCbUopFlowIdx = cblut[oCbMop];
  assign iUop          = rom[oUopAddr];

  always @(posedge iClock) begin
    if (iReset) mem_pc <= 8'd0;
    else if (oPcInc) mem_pc <= mem_pc + 8'd1;
  end

  // Expected per-cycle picture of the outputs.
  typedef struct {
    logic       v, inc, done;
    logic [7:0] addr, mop, cb;
    logic [4:0] op;
    logic [3:0] rg;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_addr = 8'd0, m_mop = 8'd0, m_cb = 8'd0, m_pc = 8'd0;

  // Expand one macro-op into its cycle trace: fetch, dispatch, then the ROM flow.
  task automatic expandMacroOp();
    exp_t r;
    logic [7:0]  a, opc;
    logic [11:0] w;
    logic [2:0]  fl;
    logic        pinc;
    opc = prog[m_pc];
    r.v = 0; r.inc = 0; r.done = 0; r.op = 0; r.rg = 0;
    r.addr = m_addr; r.mop = m_mop; r.cb = m_cb;
    exp_q.push_back(r);
    m_mop = opc;
    r.mop = opc;
    exp_q.push_back(r);
    a = lut[opc];
    for (int n = 0; n < 64; n++) begin
      w = rom[a];
      fl = w[11:9];
      pinc = (fl == 3'd1) || (fl == 3'd3) || (fl == 3'd4);
      r.addr = a; r.op = w[8:4]; r.rg = w[3:0];
      r.inc = pinc; r.done = 0; r.v = 1; r.mop = m_mop; r.cb = m_cb;
      if (w[8:4] == 5'd31) begin
        r.v = 0;
        exp_q.push_back(r);
        m_cb = prog[m_pc];
        if (pinc) m_pc = m_pc + 8'd1;
        r.inc = 0; r.cb = m_cb;
        exp_q.push_back(r);
        a = cblut[m_cb];
        continue;
      end
      if (pinc) m_pc = m_pc + 8'd1;
      if (fl == 3'd2 || fl == 3'd3) begin
        r.done = 1; exp_q.push_back(r); break;
      end
      if (fl == 3'd4 && zero) begin
        r.v = 0; r.done = 1; exp_q.push_back(r); break;
      end
      exp_q.push_back(r);
      a = a + 8'd1;
    end
    m_addr = a;
  endtask

  always @(negedge iClock) begin
    exp_t r;
    logic ok;
    if (armed) begin
      if (iReset) begin
        exp_q.delete();
        m_addr = 0; m_mop = 0; m_cb = 0; m_pc = 0;
        r.v = 0; r.inc = 0; r.done = 0; r.addr = 0; r.mop = 0; r.cb = 0; r.op = 0; r.rg = 0;
      end else begin
        if (exp_q.size() == 0) expandMacroOp();
        r = exp_q[0];
        if (iStall) begin
          r.v = 0; r.inc = 0; r.done = 0;
        end else begin
          void'(exp_q.pop_front());
        end
      end
      ok = (oUopValid === r.v) && (oPcInc === r.inc) && (oMopDone === r.done) &&
           (oUopAddr === r.addr) && (oMop === r.mop) && (oCbMop === r.cb);
      if (r.v || iReset) ok = ok && (oUopOp === r.op) && (oUopReg === r.rg);
      total_count++;
      if (ok) pass_count++;
      else $display("[TB] FAIL model t=%0t got v%0b i%0b d%0b a%02h m%02h c%02h op%0d r%0d want v%0b i%0b d%0b a%02h m%02h c%02h op%0d r%0d",
                    $time, oUopValid, oPcInc, oMopDone, oUopAddr, oMop, oCbMop, oUopOp, oUopReg,
                    r.v, r.inc, r.done, r.addr, r.mop, r.cb, r.op, r.rg);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    total_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got %h want %h", name, got, want);
  endtask

  // Strobes and micro-PC packed as {valid, pc_inc, done, addr} for literal checks.
  task automatic checkCycle(input string name, input logic [10:0] want);
    @(negedge iClock);
    checkOutput(name, {5'd0, oUopValid, oPcInc, oMopDone, oUopAddr}, {5'd0, want});
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic z);
    @(posedge iClock); #1;
    iReset = 1'b1;
    iStall = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[0] = b0; prog[1] = b1; prog[2] = b2;
    zero = z;
    @(posedge iClock);
    @(posedge iClock); #1;
    iReset = 1'b0;
  endtask

  task automatic waitIssue(input string name, input logic [7:0] addr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge iClock);
      if (oUopValid && oUopAddr == addr) seen = 1'b1;
    end
    total_count++;
    if (seen) pass_count++;
    else $display("[TB] FAIL %s: address %02h never issued, wanted it within 40 cycles", name, addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      lut[i] = 8'd0; cblut[i] = 8'd0; rom[i] = 12'h000; prog[i] = 8'h00;
    end
    lut[8'h21] = 8'd5; lut[8'hCB] = 8'd14; lut[8'h20] = 8'd19; lut[8'hCD] = 8'd50;
    cblut[8'h7C] = 8'd16;
    rom[0]  = {3'd3, 5'd2, 4'd0};
    rom[5]  = {3'd1, 5'd4, 4'd5};
    rom[6]  = {3'd1, 5'd4, 4'd4};
    rom[7]  = {3'd0, 5'd6, 4'd4};
    rom[8]  = {3'd3, 5'd7, 4'd6};
    rom[14] = {3'd1, 5'd2, 4'd0};
    rom[15] = {3'd0, 5'd31, 4'd0};
    rom[16] = {3'd3, 5'd9, 4'd7};
    rom[19] = {3'd4, 5'd10, 4'd0};
    rom[20] = {3'd1, 5'd11, 4'd1};
    rom[21] = {3'd0, 5'd12, 4'd2};
    rom[22] = {3'd2, 5'd13, 4'd3};
    rom[50] = {3'd1, 5'd3, 4'd2};
    rom[51] = {3'd1, 5'd3, 4'd3};
    for (int i = 52; i < 57; i++) rom[i] = {3'd0, 5'd14, 4'd8};
    rom[57] = {3'd3, 5'd15, 4'd9};
    armed = 1'b1;

    // Outputs while reset is held
    @(negedge iClock);
    checkOutput("reset outputs", {5'd0, oUopValid, oPcInc, oMopDone, oUopAddr},
                {5'd0, 1'b0, 1'b0, 1'b0, 8'd0});

    // LDHLnn followed by an unlisted opcode
    applyStimulus(8'h21, 8'h34, 8'h12, 1'b0);
    checkCycle("ld fetch", {3'b000, 8'd0});
    checkCycle("ld dispatch", {3'b000, 8'd0});
    checkOutput("ld mop", {8'd0, oMop}, 16'h0021);
    checkCycle("ld a5", {3'b110, 8'd5});
    checkCycle("ld a6", {3'b110, 8'd6});
    checkCycle("ld a7", {3'b100, 8'd7});
    checkCycle("ld a8", {3'b111, 8'd8});
    checkCycle("ld refetch", {3'b000, 8'd8});
    checkCycle("unk dispatch", {3'b000, 8'd8});
    checkOutput("unk mop", {8'd0, oMop}, 16'h0000);
    checkCycle("unk a0", {3'b111, 8'd0});

    // Stall for three cycles on address 6
    applyStimulus(8'h21, 8'h34, 8'h12, 1'b0);
    waitIssue("stall reach", 8'd5);
    @(posedge iClock); #1;
    iStall = 1'b1;
    checkCycle("stall 1", {3'b000, 8'd6});
    checkCycle("stall 2", {3'b000, 8'd6});
    checkCycle("stall 3", {3'b000, 8'd6});
    @(posedge iClock); #1;
    iStall = 1'b0;
    checkCycle("resume a6", {3'b110, 8'd6});
    checkCycle("resume a7", {3'b100, 8'd7});
    checkCycle("resume a8", {3'b111, 8'd8});

    // JRNZ with Z set: suppressed single micro-op
    applyStimulus(8'h20, 8'h00, 8'h00, 1'b1);
    checkCycle("jrnz z fetch", {3'b000, 8'd0});
    checkCycle("jrnz z dispatch", {3'b000, 8'd0});
    checkCycle("jrnz z a19", {3'b011, 8'd19});
    checkCycle("jrnz z refetch", {3'b000, 8'd19});

    // JRNZ with Z clear: full flow
    applyStimulus(8'h20, 8'h05, 8'h00, 1'b0);
    checkCycle("jrnz nz fetch", {3'b000, 8'd0});
    checkCycle("jrnz nz dispatch", {3'b000, 8'd0});
    checkCycle("jrnz nz a19", {3'b110, 8'd19});
    checkCycle("jrnz nz a20", {3'b110, 8'd20});
    checkCycle("jrnz nz a21", {3'b100, 8'd21});
    checkCycle("jrnz nz a22", {3'b101, 8'd22});
    checkCycle("jrnz nz refetch", {3'b000, 8'd22});
    checkCycle("jrnz nz next dispatch", {3'b000, 8'd22});
    checkOutput("jrnz nz next mop", {8'd0, oMop}, 16'h0000);

    // CB prefix then BIT 7,H
    applyStimulus(8'hCB, 8'h7C, 8'h00, 1'b0);
    checkCycle("cb fetch", {3'b000, 8'd0});
    checkCycle("cb dispatch", {3'b000, 8'd0});
    checkCycle("cb a14", {3'b110, 8'd14});
    checkCycle("cb jcb", {3'b000, 8'd15});
    checkCycle("cb cbdispatch", {3'b000, 8'd15});
    checkOutput("cb mop latched", {8'd0, oCbMop}, 16'h007C);
    checkCycle("cb bit", {3'b111, 8'd16});
    checkOutput("cb bit op", {11'd0, oUopOp}, 16'd9);

    // Reset in the middle of CALLnn
    applyStimulus(8'hCD, 8'h34, 8'h12, 1'b0);
    waitIssue("call reach", 8'd55);
    @(posedge iClock); #1;
    iReset = 1'b1;
    checkCycle("call in reset", {3'b000, 8'd0});
    @(posedge iClock); #1;
    iReset = 1'b0;
    checkCycle("call after reset", {3'b000, 8'd0});
    checkCycle("call redispatch", {3'b000, 8'd0});
    checkOutput("call refetch mop", {8'd0, oMop}, 16'h00CD);

    repeat (10) @(negedge iClock);
    armed = 1'b0;
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
